// File: rtl/riscv_pkg.sv
// Shared RV32 integer register-file constants, the write-back request type
// and a population-count helper for the pending-write scoreboard.
package riscv_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'h0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [5:0] popcount(input logic [NREGS-1:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back controller bus: instruction issue, two completion sources,
// decode operand hazard lookup and the register-file write port.
interface regfile_wb_arbiter_if;
  import riscv_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_ready;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              rs1_hazard;
  logic              rs2_hazard;
  logic              we;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [5:0]        pending_cnt;
  logic              err;
  logic              rs1_fwd;
  logic              rs2_fwd;

  modport master (
    output issue_valid, issue_rd,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rs1_addr, rs2_addr,
    input  issue_ready, req0_ready, req1_ready,
    input  rs1_hazard, rs2_hazard, rs1_fwd, rs2_fwd,
    input  we, WriteAddr, WriteData, pending_cnt, err
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rs1_addr, rs2_addr,
    output issue_ready, req0_ready, req1_ready,
    output rs1_hazard, rs2_hazard, rs1_fwd, rs2_fwd,
    output we, WriteAddr, WriteData, pending_cnt, err
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; after any grant the pointer favours
// the source that was not granted. Grant is combinational from req.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic       ptr_r;
  logic [1:0] gnt_s;

  // Lone requester wins outright; on contention the pointer picks.
  always_comb begin
    gnt_s = 2'b00;
    case (req)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11:   gnt_s = ptr_r ? 2'b10 : 2'b01;
      default: gnt_s = 2'b00;
    endcase
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= 1'b0;
    end else if (gnt_s[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt_s[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign gnt = gnt_s;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two
// completion sources and tracks pending writes. `define WB_FWD_EN adds bypass.
module regfile_wb_arbiter
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus
);
  wb_req_t           req0_s;
  wb_req_t           req1_s;
  wb_req_t           sel_s;
  logic [1:0]        gnt_s;
  logic              hs_s;
  logic              issue_ready_s;
  logic              err_set_s;
  logic [NREGS-1:0]  set_s;
  logic [NREGS-1:0]  clr_s;
  logic [NREGS-1:0]  pending_nxt_s;
  logic [NREGS-1:0]  pending_r;
  logic [5:0]        pending_cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              err_r;
  logic              rs1_fwd_s;
  logic              rs2_fwd_s;

  assign req0_s = {bus.req0_valid, bus.req0_addr, bus.req0_data};
  assign req1_s = {bus.req1_valid, bus.req1_addr, bus.req1_data};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_s.valid, req0_s.valid}),
    .gnt (gnt_s)
  );

  // An unselected source leaves sel_s on req0 with valid low, so valid is the handshake.
  assign hs_s          = sel_s.valid;
  assign issue_ready_s = !bus.issue_valid || (bus.issue_rd == REG_ZERO) || !pending_r[bus.issue_rd];

  // Winner mux and scoreboard next state.
  always_comb begin
    sel_s = req0_s;
    set_s = {NREGS{1'b0}};
    clr_s = {NREGS{1'b0}};
    if (gnt_s[1]) begin
      sel_s = req1_s;
    end else begin
      sel_s = req0_s;
    end
    if (bus.issue_valid && issue_ready_s && (bus.issue_rd != REG_ZERO)) begin
      set_s[bus.issue_rd] = 1'b1;
    end else begin
      set_s = {NREGS{1'b0}};
    end
    if (we_r) begin
      clr_s[waddr_r] = 1'b1;
    end else begin
      clr_s = {NREGS{1'b0}};
    end
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
    err_set_s     = hs_s && (sel_s.addr != REG_ZERO) && !pending_r[sel_s.addr];
  end

  // Register-file write port; x0 completions are acknowledged but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      waddr_r <= REG_ZERO;
      wdata_r <= {DATA_W{1'b0}};
    end else if (hs_s) begin
      we_r    <= (sel_s.addr != REG_ZERO);
      waddr_r <= sel_s.addr;
      wdata_r <= sel_s.data;
    end else begin
      we_r    <= 1'b0;
    end
  end

  // Scoreboard mask, its population count and the sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r     <= {NREGS{1'b0}};
      pending_cnt_r <= 6'd0;
      err_r         <= 1'b0;
    end else begin
      pending_r     <= pending_nxt_s;
      pending_cnt_r <= popcount(pending_nxt_s);
      err_r         <= err_r | err_set_s;
    end
  end

`ifdef WB_FWD_EN
  assign rs1_fwd_s = we_r && (waddr_r == bus.rs1_addr) && (bus.rs1_addr != REG_ZERO);
  assign rs2_fwd_s = we_r && (waddr_r == bus.rs2_addr) && (bus.rs2_addr != REG_ZERO);
`else
  assign rs1_fwd_s = 1'b0;
  assign rs2_fwd_s = 1'b0;
`endif

  assign bus.rs1_hazard  = (bus.rs1_addr != REG_ZERO) && pending_r[bus.rs1_addr] && !rs1_fwd_s;
  assign bus.rs2_hazard  = (bus.rs2_addr != REG_ZERO) && pending_r[bus.rs2_addr] && !rs2_fwd_s;
  assign bus.rs1_fwd     = rs1_fwd_s;
  assign bus.rs2_fwd     = rs2_fwd_s;
  assign bus.issue_ready = issue_ready_s;
  assign bus.req0_ready  = gnt_s[0];
  assign bus.req1_ready  = gnt_s[1];
  assign bus.we          = we_r;
  assign bus.WriteAddr   = waddr_r;
  assign bus.WriteData   = wdata_r;
  assign bus.pending_cnt = pending_cnt_r;
  assign bus.err         = err_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, every
// cycle compared against a set/queue-based model of the write-back rules.
module tb_regfile_wb_arbiter;
  import riscv_pkg::*;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          m_pend[NREGS];
  int          m_pref;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  int          last_gnt;
  int          gnt_log[$];
  item_t       q0[$];
  item_t       q1[$];

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit fwd_exp(int rs);
    return FWD && m_we && (m_waddr == rs) && (rs != 0);
  endfunction

  function automatic int pick_reg();
    int cand[$];
    foreach (m_pend[i]) if (m_pend[i]) cand.push_back(i);
    if (cand.size() == 0 || $urandom_range(9, 0) == 0) return int'($urandom_range(31, 0));
    return cand[$urandom_range(cand.size() - 1, 0)];
  endfunction

  function automatic int log_at(int i);
    return (gnt_log.size() > i) ? gnt_log[i] : -1;
  endfunction

  task automatic drive_idle();
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic cycle();
    int g, cnt, rd, a, nwaddr;
    bit ir, fire, nwe, nerr, f1, f2, h1, h2;
    logic [31:0] d, nwdata;
    @(negedge clk);
    if (bus.req0_valid && bus.req1_valid) g = m_pref;
    else if (bus.req0_valid) g = 0;
    else if (bus.req1_valid) g = 1;
    else g = -1;
    rd   = int'(bus.issue_rd);
    ir   = !bus.issue_valid || rd == 0 || !m_pend[rd];
    fire = bus.issue_valid && ir && rd != 0;
    cnt  = 0;
    foreach (m_pend[i]) if (m_pend[i]) cnt++;
    f1 = fwd_exp(int'(bus.rs1_addr));
    f2 = fwd_exp(int'(bus.rs2_addr));
    h1 = bus.rs1_addr != 5'd0 && m_pend[bus.rs1_addr] && !f1;
    h2 = bus.rs2_addr != 5'd0 && m_pend[bus.rs2_addr] && !f2;
    check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
    check("issue_ready", 32'(bus.issue_ready), 32'(ir));
    check("rs1_hazard", 32'(bus.rs1_hazard), 32'(h1));
    check("rs2_hazard", 32'(bus.rs2_hazard), 32'(h2));
    check("rs1_fwd", 32'(bus.rs1_fwd), 32'(f1));
    check("rs2_fwd", 32'(bus.rs2_fwd), 32'(f2));
    check("we", 32'(bus.we), 32'(m_we));
    check("WriteAddr", 32'(bus.WriteAddr), 32'(m_waddr));
    check("WriteData", bus.WriteData, m_wdata);
    check("pending_cnt", 32'(bus.pending_cnt), 32'(cnt));
    check("err", 32'(bus.err), 32'(m_err));
    nwe = 1'b0; nwaddr = m_waddr; nwdata = m_wdata; nerr = m_err;
    if (g >= 0) begin
      a = (g == 0) ? int'(bus.req0_addr) : int'(bus.req1_addr);
      d = (g == 0) ? bus.req0_data : bus.req1_data;
      if (a != 0 && !m_pend[a]) nerr = 1'b1;
      nwe = (a != 0); nwaddr = a; nwdata = d;
    end
    @(posedge clk);
    last_gnt = g;
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (fire) m_pend[rd] = 1'b1;
    if (g >= 0) begin
      m_pref = 1 - g;
      gnt_log.push_back(g);
    end
    m_we = nwe; m_waddr = nwaddr; m_wdata = nwdata; m_err = nerr;
    #1;
  endtask

  task automatic issue(int rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'(rd);
    cycle();
    bus.issue_valid = 1'b0;
  endtask

  // Present queued completions, honouring hold-until-granted, within a cycle budget.
  task automatic drain(int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      bus.req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin bus.req0_addr = 5'(q0[0].addr); bus.req0_data = q0[0].data; end
      bus.req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin bus.req1_addr = 5'(q1[0].addr); bus.req1_data = q1[0].data; end
      cycle();
      n++;
      if (last_gnt == 0) q0.delete(0);
      else if (last_gnt == 1) q1.delete(0);
    end
    check("drain_done", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete(); q1.delete();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    #1;
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_pending_cnt", 32'(bus.pending_cnt), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_pref = 0; m_we = 1'b0; m_waddr = 0; m_wdata = 32'd0; m_err = 1'b0; last_gnt = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Contention: both sources valid together, req0 first.
    issue(5); issue(6);
    gnt_log.delete();
    q0.push_back('{5, 32'h11111111});
    q1.push_back('{6, 32'h22222222});
    drain(6);
    check("cont_first", 32'(log_at(0)), 32'd0);
    check("cont_second", 32'(log_at(1)), 32'd1);
    cycle(); cycle();
    check("cont_cnt_zero", 32'(bus.pending_cnt), 32'd0);

    // Fairness: req0 keeps requesting, req1 once.
    issue(10); issue(11); issue(12); issue(14);
    gnt_log.delete();
    q0.push_back('{10, $urandom()}); q0.push_back('{11, $urandom()}); q0.push_back('{12, $urandom()});
    q1.push_back('{14, $urandom()});
    drain(8);
    check("fair_g0", 32'(log_at(0)), 32'd0);
    check("fair_g1", 32'(log_at(1)), 32'd1);
    check("fair_g2", 32'(log_at(2)), 32'd0);
    cycle(); cycle();

    // RAW / WAW on x7, and issue to x0.
    issue(7);
    bus.rs1_addr = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    #1 check("waw_stall", 32'(bus.issue_ready), 32'd0);
    cycle();
    bus.issue_rd = 5'd0;
    #1 check("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
    cycle();
    bus.issue_valid = 1'b0;
    check("x0_issue_cnt", 32'(bus.pending_cnt), 32'd1);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h77777777;
    cycle();
    bus.req0_valid = 1'b0;
    check("raw_we", 32'(bus.we), 32'd1);
    check("raw_haz_we_cycle", 32'(bus.rs1_hazard), 32'(!FWD));
    cycle();
    check("raw_haz_after", 32'(bus.rs1_hazard), 32'd0);
    bus.rs1_addr = 5'd0;

    // Forwarding window on x3 via rs2.
    issue(3);
    bus.rs2_addr = 5'd3;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd3; bus.req1_data = 32'hCAFEF00D;
    cycle();
    bus.req1_valid = 1'b0;
    check("fwd_rs2_fwd", 32'(bus.rs2_fwd), 32'(FWD));
    check("fwd_rs2_hazard", 32'(bus.rs2_hazard), 32'(!FWD));
    check("fwd_wdata", bus.WriteData, 32'hCAFEF00D);
    cycle();
    bus.rs2_addr = 5'd0;

    // x0 completion, then completion to a non-pending register.
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd0; bus.req0_data = 32'hDEADBEEF;
    #1 check("x0_ready", 32'(bus.req0_ready), 32'd1);
    cycle();
    bus.req0_valid = 1'b0;
    check("x0_we", 32'(bus.we), 32'd0);
    check("x0_err", 32'(bus.err), 32'd0);
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99999999;
    cycle();
    bus.req1_valid = 1'b0;
    check("x9_we", 32'(bus.we), 32'd1);
    check("x9_addr", 32'(bus.WriteAddr), 32'd9);
    check("x9_err", 32'(bus.err), 32'd1);
    cycle(); cycle();
    check("err_sticky", 32'(bus.err), 32'd1);

    // Reset mid-stream with a write in flight and the pointer favouring req1.
    issue(20); issue(21);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd20; bus.req0_data = 32'h20202020;
    cycle();
    do_reset();
    issue(22); issue(23);
    gnt_log.delete();
    q0.push_back('{22, $urandom()});
    q1.push_back('{23, $urandom()});
    drain(6);
    check("post_rst_first", 32'(log_at(0)), 32'd0);

    // Random traffic.
    drive_idle();
    for (int c = 0; c < 2000; c++) begin
      bus.issue_valid = ($urandom_range(1, 0) == 1);
      bus.issue_rd    = 5'($urandom_range(31, 0));
      bus.rs1_addr    = 5'(pick_reg());
      bus.rs2_addr    = 5'(pick_reg());
      if (!bus.req0_valid || last_gnt == 0) begin
        bus.req0_valid = ($urandom_range(9, 0) < 6);
        bus.req0_addr  = 5'(pick_reg());
        bus.req0_data  = $urandom();
      end
      if (!bus.req1_valid || last_gnt == 1) begin
        bus.req1_valid = ($urandom_range(9, 0) < 6);
        bus.req1_addr  = 5'(pick_reg());
        bus.req1_data  = $urandom();
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
